// File: rtl/fgen_pr_frac_pkg.sv
// Shared widths and state encoding for the programmable reference generator.
// Width defaults match the reciprocal meter's Q/F outputs so its result loops back directly.
package fgen_pr_frac_pkg;

  localparam int M_DEF = 16;  // meter integer-period width
  localparam int S_DEF = 8;   // meter fractional-period width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/fgen_pr_frac_per_len_acc.sv
// Fractional period accumulator: yields period length L = Q + carry(acc + F) and
// high phase H = L/2. The clr input makes the current evaluation see acc = 0.
module per_len_acc
  import fgen_pr_frac_pkg::*;
#(
  parameter int M_W = M_DEF,
  parameter int S_W = S_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M_W-1:0] q,
  input  logic [S_W-1:0] f,
  input  logic           step,
  input  logic           clr,
  output logic [M_W:0]   l,
  output logic [M_W:0]   h
);

  logic [S_W-1:0] acc;
  logic [S_W-1:0] acc_base;
  logic [S_W:0]   sum;

  always_comb begin
    acc_base = clr ? '0 : acc;
    sum      = {1'b0, acc_base} + {1'b0, f};
    l        = {1'b0, q} + {{M_W{1'b0}}, sum[S_W]};
    h        = l >> 1;
  end

  // A start with step consumes the first period from a cleared accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (step) acc <= sum[S_W-1:0];
    else if (clr)  acc <= '0;
  end

endmodule

// File: rtl/fgen_pr_frac.sv
// Square-wave generator whose average period is Q + F/2^S_W ce ticks,
// with run-length control (N), graceful stop, restart and error flag.
module fgen_pr_frac
  import fgen_pr_frac_pkg::*;
#(
  parameter int M_W = M_DEF,
  parameter int S_W = S_DEF,
  parameter int N_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           st,
  input  logic           stop,
  input  logic [M_W-1:0] Q,
  input  logic [S_W-1:0] F,
  input  logic [N_W-1:0] N,
  output logic           Ux,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [N_W-1:0] cnt
);

  state_e         state_q, state_d;
  logic [M_W-1:0] qr;
  logic [S_W-1:0] fr;
  logic [N_W-1:0] nr;
  logic [M_W:0]   ph;
  logic [M_W:0]   l_r;
  logic           stop_pend;

  logic [M_W:0]   l, h;
  logic [N_W-1:0] cnt_inc;
  logic           q_ok, ph_last, last;
  logic           start, bad_st, to_low, per_end, finish, next_per;

  assign q_ok    = Q >= M_W'(2);
  assign ph_last = ce && (ph == (M_W+1)'(1));
  assign cnt_inc = cnt + N_W'(1);
  assign last    = ((nr != '0) && (cnt_inc == nr)) || stop_pend;

  // On a start the accumulator must see the new inputs, not the stale copies.
  per_len_acc #(.M_W(M_W), .S_W(S_W)) u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (start ? Q : qr),
    .f    (start ? F : fr),
    .step (start || next_per),
    .clr  (start),
    .l    (l),
    .h    (h)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    bad_st  = 1'b0;
    to_low  = 1'b0;
    per_end = 1'b0;
    if (st) begin
      if (q_ok) begin
        start   = 1'b1;
        state_d = ST_HIGH;
      end else begin
        bad_st  = 1'b1;
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_HIGH: if (ph_last) begin
          to_low  = 1'b1;
          state_d = ST_LOW;
        end
        ST_LOW: if (ph_last) begin
          per_end = 1'b1;
          state_d = last ? ST_IDLE : ST_HIGH;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    finish   = per_end && last;
    next_per = per_end && !last;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Ux        <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      qr        <= '0;
      fr        <= '0;
      nr        <= '0;
      ph        <= '0;
      l_r       <= '0;
      stop_pend <= 1'b0;
    end else begin
      done <= finish;

      if (start) begin
        qr  <= Q;
        fr  <= F;
        nr  <= N;
        err <= 1'b0;
      end else if (bad_st) begin
        err <= 1'b1;
      end

      if (start)        cnt <= '0;
      else if (per_end) cnt <= cnt_inc;

      if (start || next_per) begin
        l_r <= l;
        ph  <= h;
        Ux  <= 1'b1;
      end else if (to_low) begin
        ph  <= l_r - (l_r >> 1);
        Ux  <= 1'b0;
      end else begin
        if (finish || bad_st) Ux <= 1'b0;
        if (busy && ce)       ph <= ph - (M_W+1)'(1);
      end

      if (st || finish)      stop_pend <= 1'b0;
      else if (stop && busy) stop_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fgen_pr_frac.sv
// Directed-vector bench for fgen_pr_frac with hand-computed waveforms (M_W=16, S_W=8).
module tb_fgen_pr_frac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        st = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] Q = '0;
  logic [7:0]  F = '0;
  logic [15:0] N = '0;
  logic        Ux, busy, done, err;
  logic [15:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fgen_pr_frac #(.M_W(16), .S_W(8), .N_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .st   (st),
    .stop (stop),
    .Q    (Q),
    .F    (F),
    .N    (N),
    .Ux   (Ux),
    .busy (busy),
    .done (done),
    .err  (err),
    .cnt  (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse st so that it is sampled by the next rising edge (edge 0 of the run).
  task automatic start_run(input logic [15:0] q, input logic [7:0] f, input logic [15:0] n);
    Q  = q;
    F  = f;
    N  = n;
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({Ux, busy, done, err} !== 4'b0000 || cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state got Ux=%b busy=%b done=%b err=%b cnt=%0d want all 0", Ux, busy, done, err, cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic exp_ux;
    ce = 1'b1;
    start_run(16'd10, 8'd0, 16'd3);
    for (int e = 0; e < 30; e++) begin
      if (e > 0) tick();
      exp_ux = (e % 10) < 5;
      n_cmp++;
      if (Ux !== exp_ux || done !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL basic_wave e=%0d got Ux=%b done=%b busy=%b want Ux=%b done=0 busy=1", e, Ux, done, busy, exp_ux);
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || Ux !== 1'b0 || busy !== 1'b0 || cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL basic_end got done=%b Ux=%b busy=%b cnt=%0d want 1 0 0 3", done, Ux, busy, cnt);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL basic_done_pulse got done=%b cnt=%0d want 0 3", done, cnt);
    end
  endtask

  task automatic test_frac();
    int   lens [4] = '{4, 5, 4, 5};
    int   per_start = 0;
    int   p = 0;
    logic exp_ux;
    ce = 1'b1;
    start_run(16'd4, 8'h80, 16'd4);
    for (int e = 0; e < 18; e++) begin
      if (e > 0) tick();
      while (e >= per_start + lens[p]) begin
        per_start += lens[p];
        p++;
      end
      exp_ux = (e - per_start) < (lens[p] / 2);
      n_cmp++;
      if (Ux !== exp_ux || done !== 1'b0) begin
        n_bad++;
        $display("FAIL frac_wave e=%0d got Ux=%b done=%b want Ux=%b done=0", e, Ux, done, exp_ux);
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || Ux !== 1'b0 || busy !== 1'b0 || cnt !== 16'd4 || dut.u_acc.acc !== 8'd0) begin
      n_bad++;
      $display("FAIL frac_end got done=%b Ux=%b busy=%b cnt=%0d acc=%0d want 1 0 0 4 0", done, Ux, busy, cnt, dut.u_acc.acc);
    end
  endtask

  task automatic test_ce_div();
    int   n_done = 0;
    logic exp_ux;
    ce = 1'b0;
    start_run(16'd6, 8'd0, 16'd1);
    for (int e = 1; e <= 20; e++) begin
      ce = (e % 3 == 0);
      tick();
      if (done === 1'b1) n_done++;
      if (e < 18) begin
        exp_ux = e < 9;
        n_cmp++;
        if (Ux !== exp_ux || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL ce_wave e=%0d got Ux=%b busy=%b want Ux=%b busy=1", e, Ux, busy, exp_ux);
        end
      end else if (e == 18) begin
        n_cmp++;
        if (done !== 1'b1 || Ux !== 1'b0 || busy !== 1'b0 || cnt !== 16'd1) begin
          n_bad++;
          $display("FAIL ce_end got done=%b Ux=%b busy=%b cnt=%0d want 1 0 0 1", done, Ux, busy, cnt);
        end
      end
    end
    n_cmp++;
    if (n_done != 1) begin
      n_bad++;
      $display("FAIL ce_done_count got %0d want 1", n_done);
    end
    ce = 1'b1;
  endtask

  task automatic test_err();
    ce = 1'b1;
    start_run(16'd1, 8'd0, 16'd1);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || Ux !== 1'b0) begin
      n_bad++;
      $display("FAIL err_set got err=%b busy=%b Ux=%b want 1 0 0", err, busy, Ux);
    end
    tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky got %b want 1", err);
    end
    start_run(16'd2, 8'd0, 16'd1);
    n_cmp++;
    if (err !== 1'b0 || Ux !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL err_clear got err=%b Ux=%b busy=%b want 0 1 1", err, Ux, busy);
    end
    tick();
    n_cmp++;
    if (Ux !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL q2_low got Ux=%b busy=%b done=%b want 0 1 0", Ux, busy, done);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL q2_end got done=%b busy=%b cnt=%0d want 1 0 1", done, busy, cnt);
    end
  endtask

  task automatic test_stop();
    ce = 1'b1;
    start_run(16'd8, 8'd0, 16'd0);
    for (int e = 1; e <= 17; e++) tick();
    stop = 1'b1;
    tick();  // edge 18: stop sampled mid-HIGH of period 3
    stop = 1'b0;
    for (int e = 19; e <= 23; e++) tick();
    n_cmp++;
    if (Ux !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL stop_pre got Ux=%b busy=%b done=%b cnt=%0d want 0 1 0 2", Ux, busy, done, cnt);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || Ux !== 1'b0 || busy !== 1'b0 || cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL stop_end got done=%b Ux=%b busy=%b cnt=%0d want 1 0 0 3", done, Ux, busy, cnt);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_async_reset();
    ce = 1'b1;
    start_run(16'd10, 8'd0, 16'd0);
    for (int e = 1; e <= 12; e++) tick();
    n_cmp++;
    if (Ux !== 1'b1 || cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL arst_pre got Ux=%b cnt=%0d want 1 1", Ux, cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (Ux !== 1'b0 || busy !== 1'b0 || cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL arst_mid got Ux=%b busy=%b cnt=%0d want 0 0 0", Ux, busy, cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_restart();
    ce = 1'b1;
    start_run(16'd10, 8'd0, 16'd5);
    for (int e = 1; e <= 17; e++) tick();
    n_cmp++;
    if (Ux !== 1'b0 || cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL restart_pre got Ux=%b cnt=%0d want 0 1", Ux, cnt);
    end
    start_run(16'd6, 8'd0, 16'd5);
    n_cmp++;
    if (Ux !== 1'b1 || cnt !== 16'd0 || done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_go got Ux=%b cnt=%0d done=%b busy=%b want 1 0 0 1", Ux, cnt, done, busy);
    end
    tick();
    tick();
    n_cmp++;
    if (Ux !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_high got Ux=%b done=%b want 1 0", Ux, done);
    end
    tick();
    n_cmp++;
    if (Ux !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_low got Ux=%b done=%b want 0 0", Ux, done);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_ce_div();
    test_err();
    test_stop();
    test_async_reset();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fgen_pr_frac.md
# fgen_pr_frac

Programmable reference-signal generator: the transmit-side counterpart of the reciprocal frequency meter. It takes a period expressed in the meter's output format and synthesises a square wave `Ux` with that period:

- integer part `Q` and fractional part `F`, both counted in `ce` ticks;
- the average period equals Q + F/2^S_W ticks, spread across periods with a fractional accumulator;
- the block drives the meter's `Ux` input for closed-loop self-test and can also be used as a stand-alone stimulus source.

## Interface
Parameters:
- M_W, default `` `m_M `` (from CONST.v): width of integer period `Q`
- S_W, default `` `m_S `` (from CONST.v): width of fractional period `F`
- N_W, default 16: width of period-count request and counter

Ports:
- clk  in  1  single system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  tick enable; phase durations are counted in clk cycles with ce=1
- st  in  1  one-cycle load/start strobe; samples Q, F, N
- stop  in  1  request graceful stop after the current period
- Q  in  M_W  integer period in ce ticks; must be ≥2
- F  in  S_W  fractional period, units of 2^-S_W tick
- N  in  N_W  number of periods to emit; 0 = continuous
- Ux  out  1  generated square wave (registered)
- busy  out  1  high while in HIGH or LOW state
- done  out  1  one-cycle pulse when a run ends normally
- err  out  1  sticky; set when st is sampled with Q<2, cleared by next valid st
- cnt  out  N_W  number of completed periods in the current run

## Operation
- States: IDLE, HIGH, LOW.
- Registered copies: Qr, Fr, Nr. Fractional accumulator acc is S_W bits. Phase down-counter ph is M_W+1 bits. Period-length register L is M_W+1 bits.
- Period length: {c, acc'} = acc + Fr, then L = Qr + c, then acc ← acc'. Evaluated once at the start of every period; the first period uses acc=0.
- High phase H = L>>1 (floor). Low phase = L − H. L ≥2 guarantees both phases are ≥1 tick.
- IDLE + st:
  - If Q<2: err←1, remain IDLE, Ux=0.
  - Otherwise: latch inputs, clear acc/cnt/err, compute the first L, ph←H, Ux←1, go to HIGH. Counting the start edge does not require ce.
- HIGH: on a ce cycle, if ph==1 then ph←L−H, Ux←0, go to LOW; else ph←ph−1.
- LOW: on a ce cycle, if ph==1 the period ends: cnt←cnt+1, then:
  - if (Nr≠0 and cnt+1==Nr) or stop_pend: done←1, Ux←0, go to IDLE;
  - else compute the next L, ph←H, Ux←1, go to HIGH.
  Otherwise ph←ph−1.
- stop is latched into stop_pend while busy. It is cleared on entry to IDLE and on st. A stop in IDLE is ignored.
- st while busy restarts immediately with the same action as IDLE+st; the in-flight period is abandoned and done is not pulsed. If Q<2 on that st: err←1, go to IDLE, Ux←0.
- st and stop in the same cycle: st wins, stop discarded.
- cnt wraps modulo 2^N_W in continuous mode; it holds its value in IDLE until the next st.

## Timing
- Reset values: Ux=0, busy=0, done=0, err=0, cnt=0, state=IDLE, acc=0, stop_pend=0. Reset acts asynchronously, including mid-period.
- Ux rises at the clk edge that samples st. That is one-cycle latency from the st input to Ux=1.
- Ux changes only on edges where ce=1, except the start edge.
- done is asserted for exactly one clk, on the same edge where Ux falls to 0 at the end of the final period. busy falls on that same edge.
- Over any 2^S_W consecutive periods, the total length is exactly Q·2^S_W + F ticks.
- With ce tied high, period k lasts exactly L_k clk cycles with no dead cycle between periods.

## Structure
- Use shared CONST.v for the macros `` `m_M `` and `` `m_S ``. Widths must match the meter's Q/F outputs so that its result can be looped back directly. State encodings are local parameters.
- One sub-module: `per_len_acc`. It holds acc, takes Qr/Fr and a `step`/`clr` pair, and outputs L and H combinationally from the current acc. The FSM and counters stay in the top module.

## Test plan
- ce=1, Q=10, F=0, N=3, st pulse → Ux high 5 / low 5 clk ×3; done at 30 clk after st; cnt=3; busy low afterwards.
- ce=1, S_W=8, Q=4, F=0x80, N=4 → period lengths 4,5,4,5 (H=2,2,2,2); done after 18 clk; acc=0 at end.
- ce high every 3rd clk, Q=6, F=0, N=1 → Ux high for 3 ce ticks (9 clk), low for 3 ticks; single done pulse.
- Q=1, st → err=1, busy=0, Ux=0. Then Q=2, N=1, st → err clears; Ux high 1 tick, low 1 tick.
- N=0, Q=8, running → stop pulse mid-HIGH → the current period completes, then done; Ux=0; cnt equals the number of completed periods.
- rst_n low mid-HIGH → Ux, busy, cnt go to 0 without a clk edge. Separately, st mid-LOW with a new Q → immediate Ux=1, cnt=0, no done pulse.
